// File: rtl/webp_mb_out_drain.sv
// Drains one IN_W-bit macroblock result per FIFO pop and streams it as OUT_W-bit beats.
// Optional zero-gap prefetch of the next macroblock: define WEBP_DRAIN_PREFETCH_EN.
module webp_mb_out_drain #(
  parameter int IN_W  = 1024,
  parameter int OUT_W = 256,
  parameter int CNT_W = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [9:0]       mb_w,
  input  logic [9:0]       mb_h,
  input  logic             fifo_empty,
  output logic             fifo_rd,
  input  logic [IN_W-1:0]  fifo_dout,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [OUT_W-1:0] m_data,
  output logic             m_last,
  output logic [CNT_W-1:0] mb_count,
  output logic             busy,
  output logic             done,
  output logic [2:0]       dbg_state
);

  localparam int BEATS = IN_W / OUT_W;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_INIT = 3'd1,
    S_RD   = 3'd2,
    S_CAPT = 3'd3,
    S_SEND = 3'd4,
    S_DONE = 3'd5
  } state_t;

  state_t                      r_state;
  state_t                      w_next;
  logic [9:0]                  r_mb_w;
  logic [9:0]                  r_mb_h;
  logic [CNT_W-1:0]            r_total;
  logic [CNT_W-1:0]            r_mb_count;
  logic [CNT_W-1:0]            w_total_calc;
  logic [BW-1:0]               r_beat;
  logic [IN_W-1:0]             r_hold;
  logic [BEATS-1:0][OUT_W-1:0] w_hold_v;
  logic                        w_hs;
  logic                        w_last_beat;
  logic                        w_mb_done;
  logic                        w_frame_end;
  logic                        w_pf_pop;
  logic                        w_pf_avail;

  // Stream handshake: a beat transfers on a cycle with m_valid & m_ready; while
  // m_valid is high and m_ready low, m_data/m_last hold and m_valid stays high.
  assign m_valid      = (r_state == S_SEND);
  assign w_hs         = m_valid & m_ready;
  assign w_last_beat  = (r_beat == LAST_BEAT);
  assign w_mb_done    = w_hs & w_last_beat;
  assign w_frame_end  = ((r_mb_count + CNT_W'(1)) == r_total);
  assign w_total_calc = CNT_W'(r_mb_w) * CNT_W'(r_mb_h);

`ifdef WEBP_DRAIN_PREFETCH_EN
  logic [IN_W-1:0] r_pf;
  logic            r_pf_valid;
  logic            r_pf_pend;
  logic            w_more;

  // Only fetch ahead while another macroblock remains after the one on the wire;
  // the pop is withheld on the final handshake so RD never double-pops.
  assign w_more     = ((r_mb_count + CNT_W'(1)) < r_total);
  assign w_pf_pop   = (r_state == S_SEND) & ~r_pf_valid & ~r_pf_pend & ~fifo_empty
                    & w_more & ~w_mb_done;
  assign w_pf_avail = r_pf_valid | r_pf_pend;
`else
  assign w_pf_pop   = 1'b0;
  assign w_pf_avail = 1'b0;
`endif

  assign fifo_rd   = ((r_state == S_RD) & ~fifo_empty) | w_pf_pop;
  assign w_hold_v  = r_hold;
  assign m_data    = w_hold_v[r_beat];
  assign m_last    = m_valid & w_last_beat & (r_mb_count == (r_total - CNT_W'(1)));
  assign mb_count  = r_mb_count;
  assign busy      = (r_state == S_INIT) | (r_state == S_RD) |
                     (r_state == S_CAPT) | (r_state == S_SEND);
  assign done      = (r_state == S_DONE);
  assign dbg_state = r_state;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (start) w_next = S_INIT;
      S_INIT: w_next = (w_total_calc == '0) ? S_DONE : S_RD;
      S_RD:   if (!fifo_empty) w_next = S_CAPT;
      S_CAPT: w_next = S_SEND;
      S_SEND: begin
        if (w_mb_done) begin
          if (w_frame_end)     w_next = S_DONE;
          else if (w_pf_avail) w_next = S_SEND;
          else                 w_next = S_RD;
        end
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_mb_w     <= '0;
      r_mb_h     <= '0;
      r_total    <= '0;
      r_mb_count <= '0;
      r_beat     <= '0;
      r_hold     <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_mb_w <= mb_w;
            r_mb_h <= mb_h;
          end
        end
        S_INIT: begin
          r_total    <= w_total_calc;
          r_mb_count <= '0;
          r_beat     <= '0;
        end
        S_CAPT: r_hold <= fifo_dout;
        S_SEND: begin
          if (w_hs) begin
            if (w_last_beat) begin
              r_beat     <= '0;
              r_mb_count <= r_mb_count + CNT_W'(1);
`ifdef WEBP_DRAIN_PREFETCH_EN
              // A pop issued last cycle has its data on fifo_dout right now.
              if (r_pf_valid)     r_hold <= r_pf;
              else if (r_pf_pend) r_hold <= fifo_dout;
`endif
            end else begin
              r_beat <= r_beat + BW'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

`ifdef WEBP_DRAIN_PREFETCH_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pf       <= '0;
      r_pf_valid <= 1'b0;
      r_pf_pend  <= 1'b0;
    end else if (r_state != S_SEND) begin
      r_pf_valid <= 1'b0;
      r_pf_pend  <= 1'b0;
    end else begin
      r_pf_pend <= w_pf_pop;
      if (r_pf_pend && !w_mb_done) begin
        r_pf       <= fifo_dout;
        r_pf_valid <= 1'b1;
      end else if (r_pf_valid && w_mb_done) begin
        r_pf_valid <= 1'b0;
      end
    end
  end
`endif

endmodule

// File: tb/tb_webp_mb_out_drain.sv
// Directed bench for webp_mb_out_drain: FIFO model, expected-beat scoreboard, frame timing checks.
module tb_webp_mb_out_drain;

  localparam int IN_W  = 1024;
  localparam int OUT_W = 256;
  localparam int CNT_W = 20;
  localparam int BEATS = IN_W / OUT_W;
`ifdef WEBP_DRAIN_PREFETCH_EN
  localparam bit PF = 1'b1;
`else
  localparam bit PF = 1'b0;
`endif

  // ---------------- clock / reset / DUT ----------------
  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [9:0]       mb_w;
  logic [9:0]       mb_h;
  logic             fifo_empty;
  logic             fifo_rd;
  logic [IN_W-1:0]  fifo_dout;
  logic             m_valid;
  logic             m_ready;
  logic [OUT_W-1:0] m_data;
  logic             m_last;
  logic [CNT_W-1:0] mb_count;
  logic             busy;
  logic             done;
  logic [2:0]       dbg_state;

  always #5 clk = ~clk;

  webp_mb_out_drain #(.IN_W(IN_W), .OUT_W(OUT_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .start(start), .mb_w(mb_w), .mb_h(mb_h),
    .fifo_empty(fifo_empty), .fifo_rd(fifo_rd), .fifo_dout(fifo_dout),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .mb_count(mb_count), .busy(busy), .done(done), .dbg_state(dbg_state)
  );

  // ---------------- bench state ----------------
  logic [IN_W-1:0]  fifo_q[$];
  logic [OUT_W:0]   exp_q[$];
  int               n_tests;
  int               n_fail;
  int               cyc;
  int               exp_total;
  bit               rdy_mode;
  int               hs_total;
  int               done_total;
  int               fr_start, fr_pops, fr_hs, fr_valid, fr_first, fr_gap;
  int               fr_last_end, fr_done;
  logic [31:0]      fr_first_lo;
  logic [31:0]      fr_last_hi;
  bit               prev_stall;
  bit               prev_valid;
  logic [OUT_W:0]   prev_beat;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_beat(input string name, input logic [OUT_W:0] act, input logic [OUT_W:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Word k: 32-bit lane j holds {k, j, A5C3}, so every lane of every word is unique.
  function automatic logic [IN_W-1:0] mkword(input int k);
    logic [IN_W-1:0] w;
    for (int j = 0; j < IN_W / 32; j++) w[32*j +: 32] = {k[7:0], 8'(j), 16'hA5C3};
    return w;
  endfunction

  task automatic fifo_push(input int k);
    fifo_q.push_back(mkword(k));
  endtask

  // Expected stream for one macroblock: low slice first, last flag on final beat of frame.
  task automatic exp_mb(input int k, input bit last_mb);
    logic [IN_W-1:0] w;
    w = mkword(k);
    for (int b = 0; b < BEATS; b++)
      exp_q.push_back({(last_mb && b == BEATS - 1), w[b*OUT_W +: OUT_W]});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- drivers ----------------
  task automatic fifo_proc();
    bit rd_seen;
    forever begin
      @(negedge clk);
      rd_seen = fifo_rd;
      @(posedge clk);
      #1;
      if (rd_seen && fifo_q.size() > 0) fifo_dout = fifo_q.pop_front();
      fifo_empty = (fifo_q.size() == 0);
    end
  endtask

  task automatic ready_proc();
    int idx;
    idx = 0;
    forever begin
      @(posedge clk);
      #1;
      idx = (idx + 1) % 3;
      m_ready = rdy_mode ? (idx == 0) : 1'b1;
    end
  endtask

  // ---------------- compare process ----------------
  task automatic monitor();
    logic [OUT_W:0] e;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        prev_stall = 1'b0;
        prev_valid = 1'b0;
      end else begin
        if (start) begin
          fr_start = cyc; fr_pops = 0; fr_hs = 0; fr_valid = 0; fr_first = -1;
          fr_gap = 0; fr_last_end = -1; fr_done = -1;
        end
        if (fifo_rd) begin
          fr_pops++;
          check("fifo_rd_while_empty", fifo_empty, 1'b0);
        end
        if (prev_stall) begin
          check("stall_valid_held", m_valid, 1'b1);
          check_beat("stall_beat_held", {m_last, m_data}, prev_beat);
        end
        if (m_valid) begin
          fr_valid++;
          if (fr_first < 0) fr_first = cyc - fr_start;
          if (!prev_valid && fr_last_end >= 0 && (cyc - fr_last_end - 1) > fr_gap)
            fr_gap = cyc - fr_last_end - 1;
        end
        if (m_valid && m_ready) begin
          hs_total++;
          fr_hs++;
          if (exp_q.size() == 0) begin
            check("unexpected_beat", 64'd1, 64'd0);
          end else begin
            e = exp_q.pop_front();
            check_beat("beat", {m_last, m_data}, e);
          end
          if (fr_hs == 1) fr_first_lo = m_data[31:0];
          fr_last_hi = m_data[OUT_W-1 -: 32];
          if (fr_hs % BEATS == 0) fr_last_end = cyc;
        end
        prev_stall = m_valid && !m_ready;
        prev_valid = m_valid;
        prev_beat  = {m_last, m_data};
        if (done) begin
          done_total++;
          fr_done = cyc - fr_start;
          check("done_mb_count", 64'(mb_count), 64'(exp_total));
          check("done_beats_left", 64'(exp_q.size()), 64'd0);
          check("done_busy_low", busy, 1'b0);
        end
      end
    end
  endtask

  task automatic start_frame(input int w, input int h, input int total);
    exp_total = total;
    mb_w  = 10'(w);
    mb_h  = 10'(h);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string name);
    int d0;
    int i;
    d0 = done_total;
    i  = 0;
    while (done_total == d0 && i < budget) begin
      tick();
      i++;
    end
    check(name, 64'(done_total != d0), 64'd1);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_m_valid"},  m_valid,  1'b0);
    check({tag, "_fifo_rd"},  fifo_rd,  1'b0);
    check({tag, "_busy"},     busy,     1'b0);
    check({tag, "_done"},     done,     1'b0);
    check({tag, "_m_last"},   m_last,   1'b0);
    check({tag, "_mb_count"}, 64'(mb_count), 64'd0);
    check({tag, "_m_data"},   64'(m_data == '0), 64'd1);
    check({tag, "_state"},    dbg_state, 3'd0);
  endtask

  // ---------------- sequence ----------------
  initial begin
    int guard;
    n_tests = 0; n_fail = 0; cyc = 0; exp_total = 0; rdy_mode = 1'b0;
    hs_total = 0; done_total = 0;
    fr_start = 0; fr_pops = 0; fr_hs = 0; fr_valid = 0; fr_first = -1; fr_gap = 0;
    fr_last_end = -1; fr_done = -1; fr_first_lo = '0; fr_last_hi = '0;
    prev_stall = 1'b0; prev_valid = 1'b0; prev_beat = '0;
    rst = 1'b1; start = 1'b0; mb_w = '0; mb_h = '0;
    fifo_empty = 1'b1; fifo_dout = '0; m_ready = 1'b1;
    fork
      fifo_proc();
      ready_proc();
      monitor();
    join_none

    repeat (3) tick();
    check_idle_outputs("reset");
    rst = 1'b0;
    tick();

    // 2x1 frame, FIFO preloaded, sink always ready
    fifo_push(1); fifo_push(2);
    exp_mb(1, 1'b0); exp_mb(2, 1'b1);
    repeat (2) tick();
    start_frame(2, 1, 2);
    wait_done(60, "t1_done_timeout");
    check("t1_done_width",   done, 1'b0);
    check("t1_first_valid",  64'(fr_first), 64'd4);
    check("t1_done_cycle",   64'(fr_done), PF ? 64'd12 : 64'd14);
    check("t1_pops",         64'(fr_pops), 64'd2);
    check("t1_handshakes",   64'(fr_hs), 64'd8);
    check("t1_gap",          64'(fr_gap), PF ? 64'd0 : 64'd2);
    check("t1_mb_count",     64'(mb_count), 64'd2);
    check("t1_A_beat0_lo",   fr_first_lo, 32'h0100_A5C3);
    check("t1_B_beat3_hi",   fr_last_hi, 32'h021F_A5C3);

    // Same frame with m_ready stalling two of every three cycles
    rdy_mode = 1'b1;
    fifo_push(3); fifo_push(4);
    exp_mb(3, 1'b0); exp_mb(4, 1'b1);
    repeat (2) tick();
    start_frame(2, 1, 2);
    wait_done(120, "t2_done_timeout");
    check("t2_handshakes", 64'(fr_hs), 64'd8);
    check("t2_pops",       64'(fr_pops), 64'd2);
    check("t2_mb_count",   64'(mb_count), 64'd2);
    rdy_mode = 1'b0;
    repeat (2) tick();

    // 1x1 frame starting on an empty FIFO; word arrives later
    exp_mb(5, 1'b1);
    start_frame(1, 1, 1);
    repeat (10) tick();
    check("t3_no_pop_while_empty", 64'(fr_pops), 64'd0);
    check("t3_busy_waiting",       busy, 1'b1);
    check("t3_no_valid_waiting",   64'(fr_valid), 64'd0);
    fifo_push(5);
    wait_done(40, "t3_done_timeout");
    check("t3_pops",       64'(fr_pops), 64'd1);
    check("t3_handshakes", 64'(fr_hs), 64'd4);
    check("t3_valid",      64'(fr_valid), 64'd4);
    check("t3_mb_count",   64'(mb_count), 64'd1);

    // Zero-size frame
    start_frame(0, 5, 0);
    wait_done(10, "t4_done_timeout");
    check("t4_done_cycle", 64'(fr_done), 64'd2);
    check("t4_pops",       64'(fr_pops), 64'd0);
    check("t4_valid",      64'(fr_valid), 64'd0);
    check("t4_mb_count",   64'(mb_count), 64'd0);

    // Reset while macroblock 3 of 6 is on the wire, then a fresh 1x1 frame
    for (int k = 10; k < 16; k++) fifo_push(k);
    exp_mb(10, 1'b0); exp_mb(11, 1'b0); exp_mb(12, 1'b0);
    repeat (2) tick();
    start_frame(6, 1, 6);
    guard = 0;
    while (fr_hs < 9 && guard < 100) begin
      tick();
      guard++;
    end
    check("t5_reach_mb3_timeout", 64'(fr_hs >= 9), 64'd1);
    rst = 1'b1;
    tick();
    check_idle_outputs("t5_abort");
    rst = 1'b0;
    exp_q.delete();
    tick();
    exp_mb(PF ? 14 : 13, 1'b1);
    start_frame(1, 1, 1);
    wait_done(40, "t5_done_timeout");
    check("t5_handshakes", 64'(fr_hs), 64'd4);
    check("t5_pops",       64'(fr_pops), 64'd1);
    check("t5_mb_count",   64'(mb_count), 64'd1);
    fifo_q.delete();
    repeat (2) tick();

    // 3x1 frame, FIFO full, sink always ready
    fifo_push(20); fifo_push(21); fifo_push(22);
    exp_mb(20, 1'b0); exp_mb(21, 1'b0); exp_mb(22, 1'b1);
    repeat (2) tick();
    start_frame(3, 1, 3);
    wait_done(60, "t6_done_timeout");
    check("t6_pops",       64'(fr_pops), 64'd3);
    check("t6_valid",      64'(fr_valid), 64'd12);
    check("t6_handshakes", 64'(fr_hs), 64'd12);
    check("t6_done_cycle", 64'(fr_done), PF ? 64'd16 : 64'd20);
    check("t6_gap",        64'(fr_gap), PF ? 64'd0 : 64'd2);
    check("t6_mb_count",   64'(mb_count), 64'd3);

    repeat (2) tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
